vec_chunk_packer: RTL and testbench

//  Producer-side front end for a VecFIFO write port.
//  - Accepts a one-byte-per-cycle valid/ready stream of signed int8 vector elements.
//  - Packs the bytes into BytesPerWrite-wide chunks and issues wr_en/wr_data to the FIFO.
//  - Uses byte credits returned by the consumer (e.g. the ReLU req_chunk_in pulses) so the FIFO never overflows.
//  - Marks the chunk that completes each VecElements-long vector.

---
 rtl/vec_chunk_packer_if.sv | 42 ++++
 rtl/vec_chunk_packer.sv | 120 ++++++++++++
 tb/tb_vec_chunk_packer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_chunk_packer_if.sv
// Byte stream in, chunk write port out, plus credit return and status flags
// for the VecFIFO producer-side packer.
interface vec_chunk_packer_if #(
  parameter int BytesPerWrite = 2
);
  logic                          in_valid;
  logic [7:0]                    in_data;
  logic                          in_last;
  logic                          in_ready;
  logic                          wr_en;
  logic [BytesPerWrite-1:0][7:0] wr_data;
  logic                          credit_return;
  logic                          out_vector_valid;
  logic                          err_len;
  logic                          err_credit;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output credit_return,
    input  in_ready,
    input  wr_en,
    input  wr_data,
    input  out_vector_valid,
    input  err_len,
    input  err_credit
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  credit_return,
    output in_ready,
    output wr_en,
    output wr_data,
    output out_vector_valid,
    output err_len,
    output err_credit
  );
endinterface

// File: rtl/vec_chunk_packer.sv
// Packs an int8 element stream into FIFO write chunks, gated by byte
// credits returned from the consumer; flags vector ends and misuse.
module vec_chunk_packer #(
  parameter int VecElements   = 8,
  parameter int BytesPerWrite = 2,
  parameter int CapacityBytes = 32,
  parameter int ReturnBytes   = 4
) (
  input logic clk_in,
  input logic rst_in,
  vec_chunk_packer_if.slave bus
);
  localparam int CW = $clog2(CapacityBytes + 1);
  localparam int BW = (BytesPerWrite > 1) ? $clog2(BytesPerWrite) : 1;
  localparam int EW = (VecElements > 1) ? $clog2(VecElements) : 1;
  localparam logic [CW:0] DEB  = (CW+1)'(BytesPerWrite);
  localparam logic [CW:0] RET  = (CW+1)'(ReturnBytes);
  localparam logic [CW:0] CAPW = (CW+1)'(CapacityBytes);

  typedef enum logic {FILL, PEND} state_e;

  state_e state_q, state_d;

  logic [BytesPerWrite-1:0][7:0] asm_q, chunk;
  logic [BytesPerWrite-1:0][7:0] wr_data_q;
  logic [BW-1:0] byte_idx_q;
  logic [EW-1:0] elem_idx_q;
  logic [CW-1:0] credit_q, credit_d;
  logic [CW:0]   sum;
  logic pend_last_q;
  logic wr_en_q, ovv_q, err_len_q, err_credit_q;

  logic accept, lane_last, elem_last, has_credit, complete;
  logic write, write_last, over;

  assign accept     = bus.in_valid && (state_q == FILL);
  assign lane_last  = byte_idx_q == BW'(BytesPerWrite - 1);
  assign elem_last  = elem_idx_q == EW'(VecElements - 1);
  assign has_credit = credit_q >= CW'(BytesPerWrite);
  assign complete   = accept && lane_last;

  always_ff @(posedge clk_in) begin
    if (!rst_in) state_q <= FILL;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: if (complete && !has_credit) state_d = PEND;
      PEND: if (has_credit) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    write      = 1'b0;
    write_last = 1'b0;
    unique case (1'b1)
      (state_q == FILL): begin
        write      = complete && has_credit;
        write_last = elem_last;
      end
      (state_q == PEND): begin
        write      = has_credit;
        write_last = pend_last_q;
      end
      default: ;
    endcase
  end

  // Chunk as it will look once this cycle's byte lands in its lane.
  always_comb begin
    chunk = asm_q;
    if (accept) chunk[byte_idx_q] = bus.in_data;
  end

  always_comb begin
    sum = {1'b0, credit_q}
        - (write ? DEB : '0)
        + (bus.credit_return ? RET : '0);
    over     = sum > CAPW;
    credit_d = over ? CW'(CapacityBytes) : sum[CW-1:0];
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      asm_q        <= '0;
      byte_idx_q   <= '0;
      elem_idx_q   <= '0;
      credit_q     <= CW'(CapacityBytes);
      pend_last_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      ovv_q        <= 1'b0;
      err_len_q    <= 1'b0;
      err_credit_q <= 1'b0;
    end else begin
      if (accept) begin
        asm_q      <= chunk;
        byte_idx_q <= lane_last ? '0 : byte_idx_q + BW'(1);
        elem_idx_q <= elem_last ? '0 : elem_idx_q + EW'(1);
        if (bus.in_last != elem_last) err_len_q <= 1'b1;
      end
      if (complete) pend_last_q <= elem_last;
      wr_en_q <= write;
      if (write) wr_data_q <= (state_q == PEND) ? asm_q : chunk;
      ovv_q    <= write && write_last;
      credit_q <= credit_d;
      if (over) err_credit_q <= 1'b1;
    end
  end

  assign bus.in_ready         = (state_q == FILL);
  assign bus.wr_en            = wr_en_q;
  assign bus.wr_data          = wr_data_q;
  assign bus.out_vector_valid = ovv_q;
  assign bus.err_len          = err_len_q;
  assign bus.err_credit       = err_credit_q;
endmodule

// File: tb/tb_vec_chunk_packer.sv
// Bench for vec_chunk_packer: vector table, directed corner sequences
// and a randomized run against a queue-based reference model.
module tb_vec_chunk_packer;
  localparam int VE  = 8;
  localparam int BPW = 2;
  localparam int CAP = 32;
  localparam int RB  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vec_chunk_packer_if #(.BytesPerWrite(BPW)) bus();

  vec_chunk_packer #(
    .VecElements(VE), .BytesPerWrite(BPW),
    .CapacityBytes(CAP), .ReturnBytes(RB)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.in_valid      = 1'b0;
    bus.in_data       = 8'h00;
    bus.in_last       = 1'b0;
    bus.credit_return = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Element index equals data value mod VE for these streams.
  task automatic stream_until_stall(input int start, input int maxc,
                                    output int acc, output int wr);
    logic a;
    acc = 0;
    wr  = 0;
    for (int c = 0; c < maxc; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(start + acc);
      bus.in_last  = ((start + acc) % VE) == VE - 1;
      a = bus.in_ready;
      tick();
      if (a) acc++;
      if (bus.wr_en) wr++;
      if (!bus.in_ready) break;
    end
    idle();
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        rdy;
    logic        wr;
    logic [15:0] wd;
    logic        ovv;
  } vec_t;

  vec_t tbl[10];

  // Reference model state
  logic [7:0] q[$];
  int occ, nchunk, acc_cnt;

  task automatic model_obs();
    logic [15:0] exp_w;
    if (bus.wr_en) begin
      if (q.size() < BPW) begin
        chk("rnd spurious write", 32'(q.size()), 32'(BPW));
      end else begin
        exp_w = {q[1], q[0]};
        void'(q.pop_front());
        void'(q.pop_front());
        chk("rnd wr_data", 32'(bus.wr_data), 32'(exp_w));
        chk("rnd ovv", 32'(bus.out_vector_valid),
            32'((nchunk % (VE / BPW)) == (VE / BPW) - 1));
        nchunk++;
        occ += BPW;
        chk("rnd fifo overflow", 32'(occ <= CAP), 32'd1);
      end
    end else if (bus.out_vector_valid) begin
      chk("rnd ovv without wr", 32'(bus.out_vector_valid), 32'd0);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, wr, k;
    logic a;
    logic [15:0] seen[$];

    idle();
    do_reset();
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset wr_en", 32'(bus.wr_en), 32'd0);
    chk("reset wr_data", 32'(bus.wr_data), 32'd0);
    chk("reset ovv", 32'(bus.out_vector_valid), 32'd0);
    chk("reset err_len", 32'(bus.err_len), 32'd0);
    chk("reset err_credit", 32'(bus.err_credit), 32'd0);

    // Test 1: one aligned vector at full credit
    for (int i = 0; i < 10; i++) begin
      if (i < 8)
        tbl[i] = '{1'b1, 8'(i), i == 7, 1'b1, (i % 2) == 1,
                   {8'(i), 8'(i - 1)}, i == 7};
      else
        tbl[i] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0};
    end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = tbl[i].v;
      bus.in_data  = tbl[i].d;
      bus.in_last  = tbl[i].l;
      chk("t1 in_ready", 32'(bus.in_ready), 32'(tbl[i].rdy));
      tick();
      chk("t1 wr_en", 32'(bus.wr_en), 32'(tbl[i].wr));
      if (tbl[i].wr)
        chk("t1 wr_data", 32'(bus.wr_data), 32'(tbl[i].wd));
      chk("t1 ovv", 32'(bus.out_vector_valid), 32'(tbl[i].ovv));
    end
    idle();
    chk("t1 err_len", 32'(bus.err_len), 32'd0);
    chk("t1 err_credit", 32'(bus.err_credit), 32'd0);

    // Test 2: exhaust credit, stall in PEND, release with one return
    do_reset();
    stream_until_stall(0, 60, acc, wr);
    chk("t2 accepted", 32'(acc), 32'd34);
    chk("t2 writes", 32'(wr), 32'd16);
    chk("t2 in_ready low", 32'(bus.in_ready), 32'd0);
    tick();
    tick();
    chk("t2 still stalled", 32'(bus.in_ready), 32'd0);
    chk("t2 no write", 32'(bus.wr_en), 32'd0);
    bus.credit_return = 1'b1;
    tick();
    bus.credit_return = 1'b0;
    k = 0;
    while (k < 4 && !bus.wr_en) begin
      tick();
      k++;
    end
    chk("t2 release latency", 32'(k <= 1), 32'd1);
    chk("t2 release wr_en", 32'(bus.wr_en), 32'd1);
    chk("t2 release data", 32'(bus.wr_data), 32'h2120);
    chk("t2 release ovv", 32'(bus.out_vector_valid), 32'd0);
    chk("t2 ready again", 32'(bus.in_ready), 32'd1);

    // Test 3: credit 2, write and return net out to 4
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd34;
    tick();
    bus.in_data       = 8'd35;
    bus.credit_return = 1'b1;
    tick();
    idle();
    chk("t3 wr_en", 32'(bus.wr_en), 32'd1);
    chk("t3 wr_data", 32'(bus.wr_data), 32'h2322);
    stream_until_stall(36, 30, acc, wr);
    chk("t3 accepted", 32'(acc), 32'd6);
    chk("t3 writes", 32'(wr), 32'd2);
    chk("t3 err_credit", 32'(bus.err_credit), 32'd0);
    chk("t3 err_len", 32'(bus.err_len), 32'd0);

    // Test 4: early in_last is sticky until reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      bus.in_last  = 1'b0;
      tick();
    end
    chk("t4 err_len before", 32'(bus.err_len), 32'd0);
    for (int i = 5; i < 8; i++) begin
      bus.in_data = 8'(i);
      bus.in_last = (i == 5);
      tick();
    end
    chk("t4 err_len set", 32'(bus.err_len), 32'd1);
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 8'(i);
      bus.in_last = (i == 7);
      tick();
    end
    idle();
    chk("t4 err_len sticky", 32'(bus.err_len), 32'd1);
    do_reset();
    chk("t4 err_len reset", 32'(bus.err_len), 32'd0);
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      bus.in_last  = (i == 7);
      tick();
    end
    idle();
    chk("t4 err_len clean", 32'(bus.err_len), 32'd0);

    // Test 5: reset discards a half-built chunk
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    seen.delete();
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = (i < 4);
      bus.in_data  = 8'(i);
      tick();
      if (bus.wr_en) seen.push_back(bus.wr_data);
    end
    idle();
    chk("t5 write count", 32'(seen.size()), 32'd2);
    if (seen.size() >= 2) begin
      chk("t5 first chunk", 32'(seen[0]), 32'h0100);
      chk("t5 second chunk", 32'(seen[1]), 32'h0302);
    end

    // Test 6: over-return saturates; signed bytes pass unchanged
    do_reset();
    bus.credit_return = 1'b1;
    tick();
    idle();
    chk("t6 err_credit", 32'(bus.err_credit), 32'd1);
    stream_until_stall(0, 60, acc, wr);
    chk("t6 credit capped", 32'(wr), 32'd16);
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    tick();
    bus.in_data = 8'hFE;
    tick();
    idle();
    chk("t6 signed wr_en", 32'(bus.wr_en), 32'd1);
    chk("t6 signed data", 32'(bus.wr_data), 32'hFEFF);

    // Randomized run against the queue model
    do_reset();
    q.delete();
    occ = 0;
    nchunk = 0;
    acc_cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = 8'($urandom());
      bus.in_last  = (acc_cnt % VE) == VE - 1;
      bus.credit_return = (occ >= RB) && ($urandom_range(0, 2) == 0);
      if (bus.credit_return) occ -= RB;
      a = bus.in_valid && bus.in_ready;
      tick();
      if (a) begin
        q.push_back(bus.in_data);
        acc_cnt++;
      end
      model_obs();
    end
    idle();
    for (int c = 0; c < 200 && q.size() >= BPW; c++) begin
      bus.credit_return = (occ >= RB);
      if (bus.credit_return) occ -= RB;
      tick();
      model_obs();
    end
    idle();
    chk("rnd drained", 32'(q.size() < BPW), 32'd1);
    chk("rnd chunk count", 32'(nchunk), 32'(acc_cnt / BPW));
    chk("rnd err_len", 32'(bus.err_len), 32'd0);
    chk("rnd err_credit", 32'(bus.err_credit), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
